wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the execute-stage result bus (wd/wreg/wdata).
- Carries each result through two internal pipeline registers (M, then W) and commits it to a 32x32 general register file.
- Serves the decode stage's two operand read ports.
- Resolves read-after-write hazards by forwarding from the EX input, M and W stages, so ID can source reg1/reg2 without stalling.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hardwired to zero.
- DW, 32, data width; must equal the `RegBus` width.
- AW, 5, register address width, log2(NREG).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- stall_i  in  1  1 = hold the M stage and insert a bubble into W.
- wd_i  in  AW  EX result destination register.
- wreg_i  in  1  EX result write enable.
- wdata_i  in  DW  EX result data.
- re1_i  in  1  read port 1 enable.
- raddr1_i  in  AW  read port 1 address.
- rdata1_o  out  DW  read port 1 data, combinational.
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  AW  read port 2 address.
- rdata2_o  out  DW  read port 2 data, combinational.
- commit_o  out  1  registered; 1 in a cycle where W writes the array.
- commit_addr_o  out  AW  registered; address being committed.
- commit_data_o  out  DW  registered; data being committed.

Behaviour:
- Reset, on the clock edge with rst=1:
  - M and W registers clear (wd=0, wreg=0, wdata=0).
  - All array entries clear to 0.
  - commit_o, commit_addr_o, commit_data_o clear to 0.
  - While rst=1, rdata1_o and rdata2_o are forced to 0.
  - Reset asserted mid-flight discards any in-flight M/W results; nothing is committed.
- Pipeline, per edge with rst=0:
  - If stall_i=0: M <= {wd_i, wreg_i, wdata_i}; W <= M.
  - If stall_i=1: M holds its value; W <= bubble (wreg=0).
  - If W.wreg=1 and W.wd != 0: array[W.wd] <= W.wdata, and commit_* <= W. Otherwise commit_o <= 0 and commit_addr_o/commit_data_o hold.
- Latency: an EX result reaches the array on the 3rd rising edge after it is presented, assuming no stall. Each stall cycle adds one edge.
- Writes to register 0 are accepted into M/W but never stored or committed, and are never forwarded.
- Read mux, evaluated per port, first match wins:
  1. rst=1 or re=0 -> 0.
  2. raddr = 0 -> 0.
  3. wreg_i=1 and wd_i = raddr -> wdata_i (EX forward).
  4. M.wreg=1 and M.wd = raddr -> M.wdata.
  5. W.wreg=1 and W.wd = raddr -> W.wdata (same-cycle write-through).
  6. Otherwise -> array[raddr].
- Forwarding priority gives the youngest producer precedence when several stages target the same register.
- Both read ports are independent; equal addresses on both ports return the same value.
- Simultaneous events: a stall during a W commit does not block that commit. Under stall, the held M value is still forwarded.

Optional Feature:
- Macro: WB_REGFILE_EX_FWD_EN.
- Defined: read-mux steps 3 and 4 are present, as described above.
- Undefined: steps 3 and 4 are removed. Reads return the W write-through or array value only, and the decode stage must stall on hazards against EX/M.
- Commit timing is identical in both builds.

Decomposition:
- Shared macro header holds: `RegBus`, `RegAddrBus`, `RstEnable`, `WriteEnable`, `ReadEnable`, `ZeroWord`, `NopRegAddr`, and the register count.
- One sub-module, regfile_array: the storage, synchronous reset, one write port, and two combinational read ports with W write-through.
- The pipeline registers and forwarding mux stay in wb_regfile.

Test Plan:
- Reset: pulse rst for 2 cycles, then read r1..r31 -> all read 0, commit_o = 0.
- Basic commit: present wd=5, wreg=1, wdata=0x1234_5678 for one cycle, with both read ports on r5 and EX_FWD on:
  - rdata = 0x1234_5678 in the EX, M and W cycles, and thereafter.
  - commit_o = 1 with addr 5 exactly one cycle after the 3rd edge.
- Priority: r7 written 0xAAAA_0001, then 0xBBBB_0002, then 0xCCCC_0003 on consecutive cycles -> reading r7 each cycle returns the youngest value. The final array[7] = 0xCCCC_0003.
- Zero register: wd=0, wreg=1, wdata=0xFFFF_FFFF -> rdata(r0) = 0 at every stage, and commit_o is never asserted.
- Stall: result for r3 = 0x0000_00FF in M, then stall_i = 1 for 3 cycles:
  - No commit during the stall.
  - r3 still reads 0xFF via M forwarding.
  - Commit occurs 2 edges after stall_i falls.
- Reset mid-flight and no-forward build:
  - rst asserted while r9 (value 0x55) is in M -> r9 reads 0 after reset and is never committed.
  - With WB_REGFILE_EX_FWD_EN undefined, reading r9 in the EX/M cycles returns the old value 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back stage / general register file.
// Bus widths, enable levels and the in-flight result record used by M and W.
package wb_regfile_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [REG_BUS_W-1:0]  wdata;
  } wb_res_t;

  // A stage can supply an operand only for a real (non-zero) destination.
  function automatic logic res_hits(wb_res_t res, logic [REG_ADDR_W-1:0] addr);
    return (res.wreg == WRITE_ENABLE) && (res.wd == addr) && (addr != NOP_REG_ADDR);
  endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// 32x32 register storage: synchronous clear, one write port, two combinational
// read ports with same-cycle write-through from the W stage.
module regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int NREG = REG_NUM,
  parameter int DW   = REG_BUS_W,
  parameter int AW   = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem_reg [NREG];

  logic [1:0]         re_v;
  logic [1:0][AW-1:0] ra_v;
  logic [1:0][DW-1:0] rd_v;

  assign re_v   = {re2, re1};
  assign ra_v   = {raddr2, raddr1};
  assign rdata1 = rd_v[0];
  assign rdata2 = rd_v[1];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NREG; i++) begin
        mem_reg[i] <= ZERO_WORD;
      end
    end else if ((we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR)) begin
      mem_reg[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_v[gi] =
        ((rst == RST_ENABLE) || (re_v[gi] != READ_ENABLE) || (ra_v[gi] == NOP_REG_ADDR)) ? ZERO_WORD :
        ((we == WRITE_ENABLE) && (waddr == ra_v[gi]))                                     ? wdata     :
                                                                                            mem_reg[ra_v[gi]];
    end
  endgenerate

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: carries EX results through M and W into the register file.
// Define WB_REGFILE_EX_FWD_EN to add EX and M forwarding on the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREG = REG_NUM,
  parameter int DW   = REG_BUS_W,
  parameter int AW   = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic [AW-1:0] wd_i,
  input  logic          wreg_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re1_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic          re2_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata2_o,
  output logic          commit_o,
  output logic [AW-1:0] commit_addr_o,
  output logic [DW-1:0] commit_data_o
);

  wb_res_t ex_res;
  wb_res_t m_reg, m_next;
  wb_res_t w_reg, w_next;
  logic    w_commit;

  logic          commit_reg;
  logic [AW-1:0] commit_addr_reg;
  logic [DW-1:0] commit_data_reg;

  assign ex_res   = '{wd: wd_i, wreg: wreg_i, wdata: wdata_i};
  assign w_commit = (w_reg.wreg == WRITE_ENABLE) && (w_reg.wd != NOP_REG_ADDR);

  // A stall freezes M and lets a bubble into W; W itself always drains.
  always_comb begin
    m_next = m_reg;
    w_next = '0;
    if (!stall_i) begin
      m_next = ex_res;
      w_next = m_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      m_reg           <= '0;
      w_reg           <= '0;
      commit_reg      <= 1'b0;
      commit_addr_reg <= '0;
      commit_data_reg <= '0;
    end else begin
      m_reg      <= m_next;
      w_reg      <= w_next;
      commit_reg <= w_commit;
      if (w_commit) begin
        commit_addr_reg <= w_reg.wd;
        commit_data_reg <= w_reg.wdata;
      end
    end
  end

  assign commit_o      = commit_reg;
  assign commit_addr_o = commit_addr_reg;
  assign commit_data_o = commit_data_reg;

  logic [DW-1:0] arr_rd1, arr_rd2;

  regfile_array #(
    .NREG(NREG),
    .DW  (DW),
    .AW  (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_commit),
    .waddr (w_reg.wd),
    .wdata (w_reg.wdata),
    .re1   (re1_i),
    .raddr1(raddr1_i),
    .rdata1(arr_rd1),
    .re2   (re2_i),
    .raddr2(raddr2_i),
    .rdata2(arr_rd2)
  );

  logic [1:0]         re_v;
  logic [1:0][AW-1:0] ra_v;
  logic [1:0][DW-1:0] arr_v;
  logic [1:0][DW-1:0] rd_v;

  assign re_v     = {re2_i, re1_i};
  assign ra_v     = {raddr2_i, raddr1_i};
  assign arr_v    = {arr_rd2, arr_rd1};
  assign rdata1_o = rd_v[0];
  assign rdata2_o = rd_v[1];

`ifdef WB_REGFILE_EX_FWD_EN
  // Youngest producer first: EX input, then M; W and the array come from u_array.
  function automatic logic [DW-1:0] fwd_mux(logic r, logic re, logic [AW-1:0] addr,
                                            wb_res_t ex, wb_res_t m, logic [DW-1:0] base);
    if ((r == RST_ENABLE) || (re != READ_ENABLE) || (addr == NOP_REG_ADDR)) return ZERO_WORD;
    if (res_hits(ex, addr)) return ex.wdata;
    if (res_hits(m, addr))  return m.wdata;
    return base;
  endfunction
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
`ifdef WB_REGFILE_EX_FWD_EN
      assign rd_v[gi] = fwd_mux(rst, re_v[gi], ra_v[gi], ex_res, m_reg, arr_v[gi]);
`else
      assign rd_v[gi] = arr_v[gi];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: randomized traffic against a reference
// model, a directed vector table and hand-written stall / reset sequences.
module tb_wb_regfile;

`ifdef WB_REGFILE_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_i, wreg_i, re1_i, re2_i;
  logic [4:0]  wd_i, raddr1_i, raddr2_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic        commit_o;
  logic [4:0]  commit_addr_o;
  logic [31:0] commit_data_o;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .re1_i        (re1_i),
    .raddr1_i     (raddr1_i),
    .rdata1_o     (rdata1_o),
    .re2_i        (re2_i),
    .raddr2_i     (raddr2_i),
    .rdata2_o     (rdata2_o),
    .commit_o     (commit_o),
    .commit_addr_o(commit_addr_o),
    .commit_data_o(commit_data_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the results still in flight, oldest-to-commit last,
  // plus the committed register contents and the last commit record.
  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } res_t;

  res_t        mdl_m, mdl_w;
  logic [31:0] mdl_regs [32];
  logic        mdl_c;
  logic [4:0]  mdl_ca;
  logic [31:0] mdl_cd;

  function automatic logic [31:0] mdl_read(input logic r, input logic re,
                                           input logic [4:0] a, input res_t ex);
    res_t prod[$];
    if (r || !re || a == 5'd0) return 32'd0;
    if (FWD) begin
      prod.push_back(ex);
      prod.push_back(mdl_m);
    end
    prod.push_back(mdl_w);
    foreach (prod[i]) begin
      if (prod[i].wreg && prod[i].wd == a) return prod[i].wdata;
    end
    return mdl_regs[a];
  endfunction

  task automatic mdl_edge(input logic r, input logic st, input res_t ex);
    if (r) begin
      foreach (mdl_regs[i]) mdl_regs[i] = 32'd0;
      mdl_m  = '{5'd0, 1'b0, 32'd0};
      mdl_w  = '{5'd0, 1'b0, 32'd0};
      mdl_c  = 1'b0;
      mdl_ca = 5'd0;
      mdl_cd = 32'd0;
    end else begin
      if (mdl_w.wreg && mdl_w.wd != 5'd0) begin
        mdl_regs[mdl_w.wd] = mdl_w.wdata;
        mdl_c  = 1'b1;
        mdl_ca = mdl_w.wd;
        mdl_cd = mdl_w.wdata;
      end else begin
        mdl_c = 1'b0;
      end
      if (!st) begin
        mdl_w = mdl_m;
        mdl_m = ex;
      end else begin
        mdl_w.wreg = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  logic [31:0] s_rd1, s_rd2, s_cd;
  logic        s_c;
  logic [4:0]  s_ca;

  // One clock cycle: drive inputs, sample and check against the model at
  // the falling edge, then advance the model across the rising edge.
  task automatic step(input logic r, input logic st, input logic [4:0] wd, input logic wr,
                      input logic [31:0] wdat, input logic e1, input logic [4:0] a1,
                      input logic e2, input logic [4:0] a2, input string tag);
    res_t        ex;
    logic [31:0] x1, x2;
    rst = r; stall_i = st; wd_i = wd; wreg_i = wr; wdata_i = wdat;
    re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
    ex = '{wd, wr, wdat};
    x1 = mdl_read(r, e1, a1, ex);
    x2 = mdl_read(r, e2, a2, ex);
    @(negedge clk);
    s_rd1 = rdata1_o; s_rd2 = rdata2_o;
    s_c = commit_o; s_ca = commit_addr_o; s_cd = commit_data_o;
    chk({tag, "_rdata1"}, s_rd1, x1);
    chk({tag, "_rdata2"}, s_rd2, x2);
    chk({tag, "_commit"}, {31'd0, s_c}, {31'd0, mdl_c});
    chk({tag, "_caddr"}, {27'd0, s_ca}, {27'd0, mdl_ca});
    chk({tag, "_cdata"}, s_cd, mdl_cd);
    $display("%s t=%0t rst=%0b stall=%0b ex=%0d/%0b/%h r1[%0d]=%h r2[%0d]=%h commit=%0b/%0d/%h",
             tag, $time, r, st, wd, wr, wdat, a1, s_rd1, a2, s_rd2, s_c, s_ca, s_cd);
    @(posedge clk);
    mdl_edge(r, st, ex);
    #1;
  endtask

  typedef struct {
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] wdat;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ec;
    logic [4:0]  eca;
    logic [31:0] ecd;
  } vec_t;

  localparam logic [31:0] VX = 32'h1234_5678;
  localparam logic [31:0] VA = 32'hAAAA_0001;
  localparam logic [31:0] VB = 32'hBBBB_0002;
  localparam logic [31:0] VC = 32'hCCCC_0003;

  function automatic logic [31:0] pick(input logic [31:0] fwd_val, input logic [31:0] nofwd_val);
    return FWD ? fwd_val : nofwd_val;
  endfunction

  initial begin
    vec_t        tbl [16];
    res_t        ex0;
    logic [31:0] exp_sv;

    ex0 = '{5'd0, 1'b0, 32'd0};
    rst = 1'b1; stall_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    re1_i = 1'b0; raddr1_i = '0; re2_i = 1'b0; raddr2_i = '0;
    @(posedge clk);
    mdl_edge(1'b1, 1'b0, ex0);
    #1;

    // Basic commit, same-register priority, zero register.
    tbl[0]  = '{5'd5, 1'b1, VX,           5'd5, 5'd5, pick(VX, 0),  pick(VX, 0), 1'b0, 5'd0, 32'd0};
    tbl[1]  = '{5'd0, 1'b0, 32'd0,        5'd5, 5'd5, pick(VX, 0),  pick(VX, 0), 1'b0, 5'd0, 32'd0};
    tbl[2]  = '{5'd0, 1'b0, 32'd0,        5'd5, 5'd5, VX,           VX,          1'b0, 5'd0, 32'd0};
    tbl[3]  = '{5'd0, 1'b0, 32'd0,        5'd5, 5'd5, VX,           VX,          1'b1, 5'd5, VX};
    tbl[4]  = '{5'd0, 1'b0, 32'd0,        5'd5, 5'd5, VX,           VX,          1'b0, 5'd0, 32'd0};
    tbl[5]  = '{5'd7, 1'b1, VA,           5'd7, 5'd5, pick(VA, 0),  VX,          1'b0, 5'd0, 32'd0};
    tbl[6]  = '{5'd7, 1'b1, VB,           5'd7, 5'd7, pick(VB, 0),  pick(VB, 0), 1'b0, 5'd0, 32'd0};
    tbl[7]  = '{5'd7, 1'b1, VC,           5'd7, 5'd7, pick(VC, VA), pick(VC, VA), 1'b0, 5'd0, 32'd0};
    tbl[8]  = '{5'd0, 1'b0, 32'd0,        5'd7, 5'd7, pick(VC, VB), pick(VC, VB), 1'b1, 5'd7, VA};
    tbl[9]  = '{5'd0, 1'b0, 32'd0,        5'd7, 5'd7, VC,           VC,          1'b1, 5'd7, VB};
    tbl[10] = '{5'd0, 1'b0, 32'd0,        5'd7, 5'd7, VC,           VC,          1'b1, 5'd7, VC};
    tbl[11] = '{5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd7, 32'd0,       VC,          1'b0, 5'd0, 32'd0};
    tbl[12] = '{5'd0, 1'b0, 32'd0,        5'd0, 5'd7, 32'd0,        VC,          1'b0, 5'd0, 32'd0};
    tbl[13] = '{5'd0, 1'b0, 32'd0,        5'd0, 5'd5, 32'd0,        VX,          1'b0, 5'd0, 32'd0};
    tbl[14] = '{5'd0, 1'b0, 32'd0,        5'd0, 5'd0, 32'd0,        32'd0,       1'b0, 5'd0, 32'd0};
    tbl[15] = '{5'd0, 1'b0, 32'd0,        5'd0, 5'd7, 32'd0,        VC,          1'b0, 5'd0, 32'd0};

    // Randomized traffic on a small address window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), "rand");
    end

    // Reset pulse, then every register reads zero.
    step(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd4, "rst");
    step(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd4, "rst");
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(32 - i), "sweep");
      chk("sweep_rd1", s_rd1, 32'd0);
      chk("sweep_rd2", s_rd2, 32'd0);
      chk("sweep_commit", {31'd0, s_c}, 32'd0);
    end

    foreach (tbl[i]) begin
      step(1'b0, 1'b0, tbl[i].wd, tbl[i].wr, tbl[i].wdat, 1'b1, tbl[i].a1, 1'b1, tbl[i].a2, "tbl");
      chk("tbl_rd1", s_rd1, tbl[i].e1);
      chk("tbl_rd2", s_rd2, tbl[i].e2);
      chk("tbl_commit", {31'd0, s_c}, {31'd0, tbl[i].ec});
      if (tbl[i].ec) begin
        chk("tbl_caddr", {27'd0, s_ca}, {27'd0, tbl[i].eca});
        chk("tbl_cdata", s_cd, tbl[i].ecd);
      end
    end

    // Stall with r3 held in M for three cycles.
    exp_sv = pick(32'h0000_00FF, 32'd0);
    step(1'b0, 1'b0, 5'd3, 1'b1, 32'h0000_00FF, 1'b1, 5'd3, 1'b1, 5'd3, "stall");
    chk("stall_ex_rd", s_rd1, exp_sv);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3, "stall");
      chk("stall_hold_rd", s_rd2, exp_sv);
      chk("stall_hold_commit", {31'd0, s_c}, 32'd0);
    end
    step(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3, "stall");
    chk("stall_release_rd", s_rd1, exp_sv);
    chk("stall_release_commit", {31'd0, s_c}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3, "stall");
    chk("stall_w_rd", s_rd1, 32'h0000_00FF);
    chk("stall_w_commit", {31'd0, s_c}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3, "stall");
    chk("stall_commit", {31'd0, s_c}, 32'd1);
    chk("stall_caddr", {27'd0, s_ca}, 32'd3);
    chk("stall_cdata", s_cd, 32'h0000_00FF);

    // Reset while r9 is in flight: never committed, reads zero afterwards.
    step(1'b0, 1'b0, 5'd9, 1'b1, 32'h55, 1'b1, 5'd9, 1'b1, 5'd7, "midrst");
    chk("midrst_ex_rd", s_rd1, pick(32'h55, 32'd0));
    chk("midrst_ex_rd7", s_rd2, VC);
    step(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd7, "midrst");
    chk("midrst_forced_rd1", s_rd1, 32'd0);
    chk("midrst_forced_rd2", s_rd2, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd7, "midrst");
      chk("midrst_rd9", s_rd1, 32'd0);
      chk("midrst_rd7", s_rd2, 32'd0);
      chk("midrst_commit", {31'd0, s_c}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
